// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART blocks. It holds the default bit timing and
// frame width, so receiver and transmitter agree on 8N1 at 115200 baud from a
// 100 MHz clock. It also holds the receiver state encoding, which is exported
// on the debug state output.
// -----------------------------------------------------------------------------
package uart_pkg;

    // 100 MHz / 115200 baud
    localparam int CLKS_PER_BIT_DEFAULT = 868;
    // Data bits per frame, shared with uart_transmitter
    localparam int DATA_BITS_DEFAULT    = 8;

    typedef enum logic [2:0] {
        RX_IDLE    = 3'd0,
        RX_START   = 3'd1,
        RX_DATA    = 3'd2,
        RX_STOP    = 3'd3,
        RX_RECOVER = 3'd4
    } rx_state_t;

endpackage

// File: rtl/uart_receiver_if.sv
// -----------------------------------------------------------------------------
// uart_receiver_if
// Bundle of the receiver's serial input, received-byte outputs and debug state.
//   i_rx        : serial line into the receiver (idles high)
//   o_data      : last correctly framed byte, LSB received first
//   o_valid     : one-cycle strobe, o_data is new this cycle
//   o_frame_err : one-cycle strobe, stop bit sampled low
//   o_busy      : high from start-bit detection until back in idle
//   o_state     : current receiver FSM state (debug)
// Strobe semantics: o_valid and o_frame_err are single-cycle pulses with no
// back-pressure. The consumer must capture o_data in the cycle o_valid is
// high. o_data holds its value until the next good frame.
// Modports: master = receiver side, slave = consumer/line driver side.
// -----------------------------------------------------------------------------
interface uart_receiver_if
    import uart_pkg::*;
#(
    parameter int DATA_BITS = DATA_BITS_DEFAULT
);
    logic                 i_rx;
    logic [DATA_BITS-1:0] o_data;
    logic                 o_valid;
    logic                 o_frame_err;
    logic                 o_busy;
    rx_state_t            o_state;

    modport master (
        input  i_rx,
        output o_data,
        output o_valid,
        output o_frame_err,
        output o_busy,
        output o_state
    );

    modport slave (
        output i_rx,
        input  o_data,
        input  o_valid,
        input  o_frame_err,
        input  o_busy,
        input  o_state
    );
endinterface

// File: rtl/uart_rx_sync.sv
// -----------------------------------------------------------------------------
// uart_rx_sync
// Two-flop synchronizer for the asynchronous serial line. Both flops preset to
// 1 (line idle) on reset.
//   clk     : sampling clock
//   rst_n   : asynchronous, active-low reset
//   d       : asynchronous input
//   q       : synchronized output (second flop)
//   q_live  : high once q carries a real sample of d rather than the preset
// -----------------------------------------------------------------------------
module uart_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic q_live
);
    logic [1:0] sync_ff;
    // Tracks how far real samples have propagated through the pipeline. The
    // preset 1s must not count as an observed idle line.
    logic [1:0] live_ff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_ff <= 2'b11;
            live_ff <= 2'b00;
        end else begin
            sync_ff <= {sync_ff[0], d};
            live_ff <= {live_ff[0], 1'b1};
        end
    end

    assign q      = sync_ff[1];
    assign q_live = live_ff[1];
endmodule

// File: rtl/uart_receiver.sv
// -----------------------------------------------------------------------------
// uart_receiver
// 8N1 serial-to-parallel UART receiver. i_rx is synchronized, the start bit is
// confirmed at its half-bit point, and each data bit and the stop bit are then
// sampled one full bit period apart, which puts every sample at mid-bit.
//   clk     : system clock
//   i_reset : asynchronous, active-low reset
//   rx_if   : master modport carrying i_rx and the received-byte outputs
// A good stop bit produces o_valid the cycle after the stop sample, with
// o_data updated in that same cycle. A low stop bit produces o_frame_err
// instead, and the FSM then waits in RECOVER for the line to go high.
// -----------------------------------------------------------------------------
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int DATA_BITS    = DATA_BITS_DEFAULT
) (
    input  logic            clk,
    input  logic            i_reset,
    uart_receiver_if.master rx_if
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

    logic                 rx_s;
    logic                 rx_live;
    logic                 armed;
    rx_state_t            state;
    logic [CNT_W-1:0]     cnt;
    logic [IDX_W-1:0]     idx;
    logic [DATA_BITS-1:0] shift_q;
    // Stop-bit result, turned into a strobe on the following cycle
    logic                 valid_pend;
    logic                 err_pend;

    uart_rx_sync u_sync (
        .clk    (clk),
        .rst_n  (i_reset),
        .d      (rx_if.i_rx),
        .q      (rx_s),
        .q_live (rx_live)
    );

    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            state             <= RX_IDLE;
            cnt               <= '0;
            idx               <= '0;
            shift_q           <= '0;
            armed             <= 1'b0;
            valid_pend        <= 1'b0;
            err_pend          <= 1'b0;
            rx_if.o_data      <= '0;
            rx_if.o_valid     <= 1'b0;
            rx_if.o_frame_err <= 1'b0;
            rx_if.o_busy      <= 1'b0;
        end else begin
            rx_if.o_valid     <= valid_pend;
            rx_if.o_frame_err <= err_pend;
            valid_pend        <= 1'b0;
            err_pend          <= 1'b0;
            if (valid_pend) begin
                rx_if.o_data <= shift_q;
            end

            // Only a genuinely high line arms start detection, so a line
            // held low through reset release cannot look like a start bit.
            if (rx_live && rx_s) begin
                armed <= 1'b1;
            end

            case (state)
                RX_IDLE: begin
                    if (armed && !rx_s) begin
                        state        <= RX_START;
                        cnt          <= '0;
                        rx_if.o_busy <= 1'b1;
                    end
                end

                RX_START: begin
                    if (cnt == HALF_LAST) begin
                        cnt <= '0;
                        if (!rx_s) begin
                            state <= RX_DATA;
                            idx   <= '0;
                        end else begin
                            // Low pulse shorter than half a bit: glitch
                            state        <= RX_IDLE;
                            rx_if.o_busy <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                RX_DATA: begin
                    if (cnt == FULL_LAST) begin
                        cnt          <= '0;
                        shift_q[idx] <= rx_s;
                        if (idx == IDX_LAST) begin
                            state <= RX_STOP;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                RX_STOP: begin
                    if (cnt == FULL_LAST) begin
                        cnt <= '0;
                        if (rx_s) begin
                            // Back to idle at mid-stop, ready for an
                            // immediately following start edge
                            valid_pend   <= 1'b1;
                            state        <= RX_IDLE;
                            rx_if.o_busy <= 1'b0;
                        end else begin
                            err_pend <= 1'b1;
                            state    <= RX_RECOVER;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                RX_RECOVER: begin
                    // A break stays here, so it gives one error and no
                    // false start
                    if (rx_s) begin
                        state        <= RX_IDLE;
                        rx_if.o_busy <= 1'b0;
                    end
                end

                default: begin
                    state        <= RX_IDLE;
                    rx_if.o_busy <= 1'b0;
                end
            endcase
        end
    end

    assign rx_if.o_state = state;

endmodule

// File: tb/tb_uart_receiver.sv
// -----------------------------------------------------------------------------
// tb_uart_receiver
// Directed bench for uart_receiver with CLKS_PER_BIT=4, DATA_BITS=8.
// -----------------------------------------------------------------------------
module tb_uart_receiver;
  import uart_pkg::*;

  localparam int C = 4;
  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic clk;
  logic i_reset;
  int   cyc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  uart_receiver_if #(.DATA_BITS(W)) rx_if ();

  uart_receiver #(
    .CLKS_PER_BIT (C),
    .DATA_BITS    (W)
  ) dut (
    .clk     (clk),
    .i_reset (i_reset),
    .rx_if   (rx_if)
  );

  // ---------------- scoreboard ----------------
  int n_checks;
  int n_fail;
  logic [W-1:0] exp_q[$];

  int valid_cnt;
  int ferr_cnt;
  int busy_cycles;
  int last_valid_cyc;
  int prev_valid_cyc;
  int start_cyc;
  logic prev_v;
  logic prev_f;

  initial begin
    n_checks = 0;
    n_fail = 0;
    valid_cnt = 0;
    ferr_cnt = 0;
    busy_cycles = 0;
    last_valid_cyc = 0;
    prev_valid_cyc = 0;
    start_cyc = 0;
    prev_v = 1'b0;
    prev_f = 1'b0;
  end

  always @(negedge clk) begin
    if (rx_if.o_busy === 1'b1) busy_cycles++;
    if (rx_if.o_frame_err === 1'b1) ferr_cnt++;
    if (rx_if.o_valid === 1'b1) begin
      valid_cnt++;
      prev_valid_cyc = last_valid_cyc;
      last_valid_cyc = cyc;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected_valid: got o_data=%02h, expected no strobe", rx_if.o_data);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if (rx_if.o_data !== e) begin
          n_fail++;
          $display("FAIL sb_data: got %02h, expected %02h", rx_if.o_data, e);
        end
      end
    end
    if (rx_if.o_valid === 1'b1 || rx_if.o_frame_err === 1'b1) begin
      n_checks++;
      if ((rx_if.o_valid && rx_if.o_frame_err) ||
          (rx_if.o_valid && prev_v) || (rx_if.o_frame_err && prev_f)) begin
        n_fail++;
        $display("FAIL strobe_shape: valid=%b ferr=%b prev_valid=%b prev_ferr=%b, expected single non-overlapping pulses",
                 rx_if.o_valid, rx_if.o_frame_err, prev_v, prev_f);
      end
    end
    prev_v = rx_if.o_valid;
    prev_f = rx_if.o_frame_err;
  end

  // ---------------- driver tasks ----------------
  // Called aligned to a negedge; leaves the line high afterwards.
  task automatic send_frame(input logic [W-1:0] b, input logic stop_bit);
    start_cyc = cyc + 1;
    rx_if.i_rx = 1'b0;
    repeat (C) @(negedge clk);
    for (int i = 0; i < W; i++) begin
      rx_if.i_rx = b[i];
      repeat (C) @(negedge clk);
    end
    rx_if.i_rx = stop_bit;
    repeat (C) @(negedge clk);
    rx_if.i_rx = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    i_reset = 1'b0;
    rx_if.i_rx = 1'b1;
    #1;
    n_checks++;
    if (rx_if.o_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %02h, expected 00", rx_if.o_data); end
    n_checks++;
    if (rx_if.o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b, expected 0", rx_if.o_valid); end
    n_checks++;
    if (rx_if.o_frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_ferr: got %b, expected 0", rx_if.o_frame_err); end
    n_checks++;
    if (rx_if.o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, expected 0", rx_if.o_busy); end
    n_checks++;
    if (rx_if.o_state !== RX_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d, expected %0d", rx_if.o_state, RX_IDLE); end
    repeat (3) @(negedge clk);
    i_reset = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_single_frame();
    int v0, f0;
    v0 = valid_cnt; f0 = ferr_cnt;
    exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b1);
    repeat (6) @(negedge clk);
    n_checks++;
    if (valid_cnt - v0 !== 1) begin n_fail++; $display("FAIL single_valid_count: got %0d, expected 1", valid_cnt - v0); end
    n_checks++;
    if (last_valid_cyc - start_cyc !== 41) begin n_fail++; $display("FAIL single_latency: got %0d edges, expected 41", last_valid_cyc - start_cyc); end
    n_checks++;
    if (rx_if.o_data !== 8'h55) begin n_fail++; $display("FAIL single_data_hold: got %02h, expected 55", rx_if.o_data); end
    n_checks++;
    if (ferr_cnt - f0 !== 0) begin n_fail++; $display("FAIL single_ferr: got %0d pulses, expected 0", ferr_cnt - f0); end
  endtask

  task automatic test_back_to_back();
    int v0, s1;
    v0 = valid_cnt;
    exp_q.push_back(8'hA3);
    exp_q.push_back(8'h0F);
    send_frame(8'hA3, 1'b1);
    s1 = start_cyc;
    send_frame(8'h0F, 1'b1);
    repeat (6) @(negedge clk);
    n_checks++;
    if (valid_cnt - v0 !== 2) begin n_fail++; $display("FAIL b2b_valid_count: got %0d, expected 2", valid_cnt - v0); end
    n_checks++;
    if (last_valid_cyc - prev_valid_cyc !== 40) begin n_fail++; $display("FAIL b2b_spacing: got %0d cycles, expected 40", last_valid_cyc - prev_valid_cyc); end
    n_checks++;
    if (last_valid_cyc - s1 !== 81) begin n_fail++; $display("FAIL b2b_second_latency: got %0d, expected 81", last_valid_cyc - s1); end
    n_checks++;
    if (rx_if.o_data !== 8'h0F) begin n_fail++; $display("FAIL b2b_data: got %02h, expected 0F", rx_if.o_data); end
  endtask

  task automatic test_glitch();
    int v0, f0, b0;
    v0 = valid_cnt; f0 = ferr_cnt; b0 = busy_cycles;
    rx_if.i_rx = 1'b0;
    @(negedge clk);
    rx_if.i_rx = 1'b1;
    repeat (12) @(negedge clk);
    n_checks++;
    if (busy_cycles - b0 !== C / 2) begin n_fail++; $display("FAIL glitch_busy_len: got %0d cycles, expected %0d", busy_cycles - b0, C / 2); end
    n_checks++;
    if (valid_cnt - v0 !== 0 || ferr_cnt - f0 !== 0) begin n_fail++; $display("FAIL glitch_strobes: got valid=%0d ferr=%0d, expected 0/0", valid_cnt - v0, ferr_cnt - f0); end
    n_checks++;
    if (rx_if.o_state !== RX_IDLE || rx_if.o_busy !== 1'b0) begin n_fail++; $display("FAIL glitch_state: got state=%0d busy=%b, expected IDLE/0", rx_if.o_state, rx_if.o_busy); end
  endtask

  task automatic test_frame_error();
    int v0, f0;
    v0 = valid_cnt; f0 = ferr_cnt;
    send_frame(8'h3C, 1'b0);
    repeat (8) @(negedge clk);
    n_checks++;
    if (ferr_cnt - f0 !== 1) begin n_fail++; $display("FAIL ferr_count: got %0d, expected 1", ferr_cnt - f0); end
    n_checks++;
    if (valid_cnt - v0 !== 0) begin n_fail++; $display("FAIL ferr_no_valid: got %0d, expected 0", valid_cnt - v0); end
    n_checks++;
    if (rx_if.o_data !== 8'h0F) begin n_fail++; $display("FAIL ferr_data_kept: got %02h, expected 0F", rx_if.o_data); end
    n_checks++;
    if (rx_if.o_state !== RX_IDLE) begin n_fail++; $display("FAIL ferr_recover: got state %0d, expected IDLE", rx_if.o_state); end
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1);
    repeat (6) @(negedge clk);
    n_checks++;
    if (rx_if.o_data !== 8'h81 || valid_cnt - v0 !== 1) begin n_fail++; $display("FAIL ferr_next_frame: got %02h count=%0d, expected 81 count=1", rx_if.o_data, valid_cnt - v0); end
  endtask

  task automatic test_low_at_reset();
    int v0, f0, b0;
    rx_if.i_rx = 1'b0;
    i_reset = 1'b0;
    repeat (2) @(negedge clk);
    i_reset = 1'b1;
    v0 = valid_cnt; f0 = ferr_cnt; b0 = busy_cycles;
    repeat (50) @(negedge clk);
    rx_if.i_rx = 1'b1;
    repeat (10) @(negedge clk);
    n_checks++;
    if (busy_cycles - b0 !== 0) begin n_fail++; $display("FAIL lowrst_busy: got %0d busy cycles, expected 0", busy_cycles - b0); end
    n_checks++;
    if (valid_cnt - v0 !== 0 || ferr_cnt - f0 !== 0) begin n_fail++; $display("FAIL lowrst_strobes: got valid=%0d ferr=%0d, expected 0/0", valid_cnt - v0, ferr_cnt - f0); end
    exp_q.push_back(8'hFF);
    send_frame(8'hFF, 1'b1);
    repeat (6) @(negedge clk);
    n_checks++;
    if (rx_if.o_data !== 8'hFF || valid_cnt - v0 !== 1) begin n_fail++; $display("FAIL lowrst_next_frame: got %02h count=%0d, expected FF count=1", rx_if.o_data, valid_cnt - v0); end
  endtask

  task automatic test_reset_mid_frame();
    int v0, f0;
    logic [W-1:0] b;
    b = 8'h77;
    v0 = valid_cnt; f0 = ferr_cnt;
    rx_if.i_rx = 1'b0;
    repeat (C) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rx_if.i_rx = b[i];
      repeat (C) @(negedge clk);
    end
    n_checks++;
    if (rx_if.o_state !== RX_DATA || rx_if.o_busy !== 1'b1) begin n_fail++; $display("FAIL midrst_pre: got state=%0d busy=%b, expected DATA/1", rx_if.o_state, rx_if.o_busy); end
    i_reset = 1'b0;
    #1;
    n_checks++;
    if (rx_if.o_state !== RX_IDLE || rx_if.o_busy !== 1'b0 || rx_if.o_data !== 8'h00) begin
      n_fail++; $display("FAIL midrst_outputs: got state=%0d busy=%b data=%02h, expected IDLE/0/00", rx_if.o_state, rx_if.o_busy, rx_if.o_data);
    end
    rx_if.i_rx = 1'b1;
    repeat (3) @(negedge clk);
    i_reset = 1'b1;
    repeat (40) @(negedge clk);
    n_checks++;
    if (valid_cnt - v0 !== 0 || ferr_cnt - f0 !== 0) begin n_fail++; $display("FAIL midrst_strobes: got valid=%0d ferr=%0d, expected 0/0", valid_cnt - v0, ferr_cnt - f0); end
    exp_q.push_back(8'h12);
    send_frame(8'h12, 1'b1);
    repeat (6) @(negedge clk);
    n_checks++;
    if (rx_if.o_data !== 8'h12 || valid_cnt - v0 !== 1) begin n_fail++; $display("FAIL midrst_next_frame: got %02h count=%0d, expected 12 count=1", rx_if.o_data, valid_cnt - v0); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_glitch();
    test_frame_error();
    test_low_at_reset();
    test_reset_mid_frame();
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL sb_leftover: got %0d pending bytes, expected 0", exp_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
